// File: rtl/loader_pkg.sv
// loader_pkg
//   Shared definitions for the program loader: the loader state encoding,
//   the frame sync byte and the width of the frame length field.
package loader_pkg;

   localparam int         LEN_WIDTH = 16;
   localparam logic [7:0] SYNC_BYTE = 8'hA5;

   typedef enum logic [2:0] {
      IDLE,
      LEN_LO,
      LEN_HI,
      DATA,
      CHECK,
      RUN,
      ERROR
   } loader_state_t;

endpackage

// File: rtl/loader_timeout_counter.sv
// loader_timeout_counter
//   Counts idle cycles between received bytes and flags a gap that reaches
//   TIMEOUT_CYCLES.
// Ports:
//   clk     in   clock
//   rst     in   asynchronous active-low reset
//   enable  in   count only while a frame is in progress
//   clear   in   a byte arrived this cycle, restart the gap count
//   expired out  one-cycle pulse: this edge completes TIMEOUT_CYCLES idle cycles
module loader_timeout_counter #(
   parameter int TIMEOUT_CYCLES = 1_000_000
) (
   input  logic clk,
   input  logic rst,
   input  logic enable,
   input  logic clear,
   output logic expired
);

   localparam int                   CNT_WIDTH = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CNT_WIDTH-1:0] LAST_IDLE = CNT_WIDTH'(TIMEOUT_CYCLES - 1);

   logic [CNT_WIDTH-1:0] count_reg;

   // The count equals the number of idle edges since the last byte, so the
   // pulse lines up with the edge that would make it TIMEOUT_CYCLES.
   assign expired = enable && !clear && (count_reg == LAST_IDLE);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         count_reg <= '0;
      end else if (!enable || clear || expired) begin
         count_reg <= '0;
      end else begin
         count_reg <= count_reg + 1'b1;
      end
   end

endmodule

// File: rtl/program_loader.sv
// program_loader
//   Receives a framed program image (A5, LEN_LO, LEN_HI, LEN*4 payload bytes,
//   CHK) from the UART byte stream, writes little-endian 32-bit words to
//   instruction memory at ascending addresses, verifies the XOR checksum and
//   releases the CPU only after a valid image is loaded.
// Ports:
//   clk, rst (async active-low)
//   rx_valid/rx_data        received byte strobe, no backpressure
//   reload                  return to IDLE (priority over rx_valid)
//   instruction_write/addr/in  instruction memory write port
//   cpu_rst, debug_enable   datapath reset / run enable (released only in RUN)
//   load_done, load_error   image accepted / frame rejected
//   word_count              words written in the current or last frame
module program_loader
   import loader_pkg::*;
#(
   parameter int ADDR_WIDTH     = 16,
   parameter int TIMEOUT_CYCLES = 1_000_000
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  rx_valid,
   input  logic [7:0]            rx_data,
   input  logic                  reload,
   output logic                  instruction_write,
   output logic [ADDR_WIDTH-1:0] instruction_addr,
   output logic [31:0]           instruction_in,
   output logic                  cpu_rst,
   output logic                  debug_enable,
   output logic                  load_done,
   output logic                  load_error,
   output logic [ADDR_WIDTH-2:0] word_count
);

   // Largest accepted image, kept at 17 bits so LEN is compared untruncated.
   localparam logic [LEN_WIDTH:0] MAX_WORDS = (LEN_WIDTH + 1)'(1 << (ADDR_WIDTH - 2));

   loader_state_t         state_reg, state_next;
   logic [LEN_WIDTH-1:0]  len_reg, len_next;
   logic [7:0]            chk_reg, chk_next;
   logic [1:0]            byte_cnt_reg, byte_cnt_next;
   logic [23:0]           word_reg;
   logic                  write_reg, write_next;
   logic [ADDR_WIDTH-1:0] addr_reg, addr_next;
   logic [31:0]           instr_reg, instr_next;
   logic                  done_reg, done_next;
   logic                  error_reg, error_next;
   logic [ADDR_WIDTH-2:0] wc_reg, wc_next;
   logic                  cpu_rst_reg, debug_en_reg;
   logic                  timeout_enable, timeout_expired;
   logic [LEN_WIDTH:0]    len_full;
   logic [2:0]            lane_sel;

   assign timeout_enable = (state_reg == LEN_LO) || (state_reg == LEN_HI) ||
                           (state_reg == DATA)   || (state_reg == CHECK);

   loader_timeout_counter #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_timeout (
      .clk    (clk),
      .rst    (rst),
      .enable (timeout_enable),
      .clear  (rx_valid),
      .expired(timeout_expired)
   );

   // Length as it will be once the LEN_HI byte in rx_data is taken.
   assign len_full = {1'b0, rx_data, len_reg[7:0]};

   // Byte lanes 0..2 of the word are held here; lane 3 goes straight from
   // rx_data into the write data.
   for (genvar gi = 0; gi < 3; gi++) begin : g_lane
      assign lane_sel[gi] = rx_valid && !reload && (state_reg == DATA) &&
                            (byte_cnt_reg == 2'(gi));
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         word_reg <= '0;
      end else begin
         for (int i = 0; i < 3; i++) begin
            if (lane_sel[i]) begin
               word_reg[8*i +: 8] <= rx_data;
            end
         end
      end
   end

   always_comb begin
      state_next    = state_reg;
      len_next      = len_reg;
      chk_next      = chk_reg;
      byte_cnt_next = byte_cnt_reg;
      write_next    = 1'b0;
      addr_next     = addr_reg;
      instr_next    = instr_reg;
      done_next     = done_reg;
      error_next    = error_reg;
      wc_next       = wc_reg;

      if (reload) begin
         state_next = IDLE;
      end else if (timeout_expired) begin
         state_next = ERROR;
         error_next = 1'b1;
      end else if (rx_valid) begin
         case (state_reg)
            IDLE, ERROR: begin
               if (rx_data == SYNC_BYTE) begin
                  state_next    = LEN_LO;
                  chk_next      = '0;
                  byte_cnt_next = '0;
                  wc_next       = '0;
                  done_next     = 1'b0;
                  error_next    = 1'b0;
               end
            end
            LEN_LO: begin
               len_next[7:0] = rx_data;
               chk_next      = chk_reg ^ rx_data;
               state_next    = LEN_HI;
            end
            LEN_HI: begin
               len_next[15:8] = rx_data;
               chk_next       = chk_reg ^ rx_data;
               if (len_full > MAX_WORDS) begin
                  state_next = ERROR;
                  error_next = 1'b1;
               end else if (len_full == '0) begin
                  state_next = CHECK;
               end else begin
                  state_next = DATA;
               end
            end
            DATA: begin
               chk_next      = chk_reg ^ rx_data;
               byte_cnt_next = byte_cnt_reg + 2'd1;
               if (byte_cnt_reg == 2'd3) begin
                  write_next = 1'b1;
                  addr_next  = ADDR_WIDTH'({wc_reg, 2'b00});
                  instr_next = {rx_data, word_reg};
                  wc_next    = wc_reg + 1'b1;
                  if ((LEN_WIDTH + 1)'(wc_reg) + 17'd1 == {1'b0, len_reg}) begin
                     state_next = CHECK;
                  end
               end
            end
            CHECK: begin
               if (rx_data == chk_reg) begin
                  state_next = RUN;
                  done_next  = 1'b1;
               end else begin
                  state_next = ERROR;
                  error_next = 1'b1;
               end
            end
            RUN: begin
            end
            default: begin
               state_next = IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg    <= IDLE;
         len_reg      <= '0;
         chk_reg      <= '0;
         byte_cnt_reg <= '0;
         write_reg    <= 1'b0;
         addr_reg     <= '0;
         instr_reg    <= '0;
         done_reg     <= 1'b0;
         error_reg    <= 1'b0;
         wc_reg       <= '0;
         cpu_rst_reg  <= 1'b1;
         debug_en_reg <= 1'b0;
      end else begin
         state_reg    <= state_next;
         len_reg      <= len_next;
         chk_reg      <= chk_next;
         byte_cnt_reg <= byte_cnt_next;
         write_reg    <= write_next;
         addr_reg     <= addr_next;
         instr_reg    <= instr_next;
         done_reg     <= done_next;
         error_reg    <= error_next;
         wc_reg       <= wc_next;
         // Registered from the next state so the CPU is released in the
         // same cycle RUN becomes current.
         cpu_rst_reg  <= (state_next != RUN);
         debug_en_reg <= (state_next == RUN);
      end
   end

   assign instruction_write = write_reg;
   assign instruction_addr  = addr_reg;
   assign instruction_in    = instr_reg;
   assign cpu_rst           = cpu_rst_reg;
   assign debug_enable      = debug_en_reg;
   assign load_done         = done_reg;
   assign load_error        = error_reg;
   assign word_count        = wc_reg;

endmodule

// File: tb/tb_program_loader.sv
module tb_program_loader;

   localparam int AW = 8;
   localparam int TO = 100;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          rx_valid = 1'b0;
   logic [7:0]    rx_data = 8'h00;
   logic          reload = 1'b0;
   logic          instruction_write;
   logic [AW-1:0] instruction_addr;
   logic [31:0]   instruction_in;
   logic          cpu_rst;
   logic          debug_enable;
   logic          load_done;
   logic          load_error;
   logic [AW-2:0] word_count;

   program_loader #(
      .ADDR_WIDTH(AW),
      .TIMEOUT_CYCLES(TO)
   ) dut (
      .clk(clk),
      .rst(rst),
      .rx_valid(rx_valid),
      .rx_data(rx_data),
      .reload(reload),
      .instruction_write(instruction_write),
      .instruction_addr(instruction_addr),
      .instruction_in(instruction_in),
      .cpu_rst(cpu_rst),
      .debug_enable(debug_enable),
      .load_done(load_done),
      .load_error(load_error),
      .word_count(word_count)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [AW-1:0] addr;
      logic [31:0]   data;
      logic [AW-2:0] wc;
   } wr_t;

   wr_t exp_q[$];
   int  checks = 0;
   int  errors = 0;
   bit  exp_done = 1'b0;
   bit  exp_error = 1'b0;
   int  exp_wc = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
      end
   endtask

   // Scoreboard monitor: every memory write is matched against the queue.
   always @(negedge clk) begin : monitor
      wr_t e;
      if (rst && instruction_write === 1'b1) begin
         if (exp_q.size() == 0) begin
            check("unexpected_write", 32'(instruction_write), 32'd0);
         end else begin
            e = exp_q.pop_front();
            $display("write addr=0x%02h data=0x%08h word_count=%0d", instruction_addr,
                     instruction_in, word_count);
            check("write_addr", 32'(instruction_addr), 32'(e.addr));
            check("write_data", instruction_in, e.data);
            check("write_word_count", 32'(word_count), 32'(e.wc));
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1);
   end

   // Called at a negedge; the byte is sampled by the following posedge.
   task automatic send_byte(input logic [7:0] b);
      rx_valid = 1'b1;
      rx_data  = b;
      @(negedge clk);
      rx_valid = 1'b0;
   endtask

   task automatic send_seq(input logic [7:0] seq[$]);
      foreach (seq[k]) send_byte(seq[k]);
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic expect_write(input int idx, input logic [31:0] data);
      wr_t e;
      e.addr = AW'(idx * 4);
      e.data = data;
      e.wc   = (AW-1)'(idx + 1);
      exp_q.push_back(e);
   endtask

   task automatic check_status(input string tag);
      check({tag, "_load_done"}, 32'(load_done), 32'(exp_done));
      check({tag, "_load_error"}, 32'(load_error), 32'(exp_error));
      check({tag, "_word_count"}, 32'(word_count), 32'(exp_wc));
      check({tag, "_cpu_rst"}, 32'(cpu_rst), 32'(!exp_done));
      check({tag, "_debug_enable"}, 32'(debug_enable), 32'(exp_done));
      check({tag, "_writes_drained"}, 32'(exp_q.size()), 32'd0);
   endtask

   task automatic do_reload();
      reload = 1'b1;
      @(negedge clk);
      reload = 1'b0;
      $display("reload");
      check("reload_cpu_rst", 32'(cpu_rst), 32'd1);
      check("reload_debug_enable", 32'(debug_enable), 32'd0);
      check("reload_load_done", 32'(load_done), 32'(exp_done));
      check("reload_load_error", 32'(load_error), 32'(exp_error));
      check("reload_word_count", 32'(word_count), 32'(exp_wc));
   endtask

   // Reference model: builds a frame from random words, predicts the writes
   // and the final outcome from the frame rules.
   task automatic run_frame(input int len, input bit corrupt, input int max_gap);
      logic [7:0]  body[$];
      logic [7:0]  chk;
      logic [31:0] w;
      logic [15:0] l16;
      body = {};
      l16  = 16'(len);
      body.push_back(l16[7:0]);
      body.push_back(l16[15:8]);
      for (int i = 0; i < len; i++) begin
         w = $urandom;
         expect_write(i, w);
         for (int k = 0; k < 4; k++) body.push_back(w[8*k +: 8]);
      end
      chk = 8'h00;
      foreach (body[k]) chk ^= body[k];
      if (corrupt) chk ^= 8'(1 << $urandom_range(0, 7));
      send_byte(8'hA5);
      idle($urandom_range(0, max_gap));
      foreach (body[k]) begin
         send_byte(body[k]);
         idle($urandom_range(0, max_gap));
      end
      send_byte(chk);
      exp_done  = !corrupt;
      exp_error = corrupt;
      exp_wc    = len;
      $display("frame len=%0d corrupt=%0d chk=0x%02h", len, corrupt, chk);
      check_status("frame");
   endtask

   initial begin
      logic [7:0] seq[$];
      logic [7:0] junk;
      bit         in_run;

      // Reset state
      idle(3);
      check("rst_instruction_write", 32'(instruction_write), 32'd0);
      check("rst_instruction_addr", 32'(instruction_addr), 32'd0);
      check("rst_instruction_in", instruction_in, 32'd0);
      check_status("rst");
      rst = 1'b1;
      @(negedge clk);

      // Two-word image
      expect_write(0, 32'h00000013);
      expect_write(1, 32'h00500093);
      seq = {8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
             8'h93, 8'h00, 8'h50, 8'h00, 8'hD2};
      send_seq(seq);
      exp_done = 1'b1; exp_error = 1'b0; exp_wc = 2;
      $display("frame two-word image");
      check_status("good");

      // Bytes in RUN, including a sync byte, are ignored
      seq = {8'hA5, 8'h02, 8'h00};
      send_seq(seq);
      check_status("run_ignore");

      do_reload();

      // Bad checksum, then the correct frame straight from ERROR
      expect_write(0, 32'h00000013);
      expect_write(1, 32'h00500093);
      seq = {8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
             8'h93, 8'h00, 8'h50, 8'h00, 8'hD3};
      send_seq(seq);
      exp_done = 1'b0; exp_error = 1'b1; exp_wc = 2;
      $display("frame bad checksum");
      check_status("badchk");
      expect_write(0, 32'h00000013);
      expect_write(1, 32'h00500093);
      seq[11] = 8'hD2;
      send_seq(seq);
      exp_done = 1'b1; exp_error = 1'b0; exp_wc = 2;
      $display("frame resend");
      check_status("resend");

      do_reload();

      // Timeout after a partial word
      seq = {8'hA5, 8'h01, 8'h00, 8'h13, 8'h00};
      send_seq(seq);
      idle(TO - 1);
      check("timeout_not_yet", 32'(load_error), 32'd0);
      idle(1);
      exp_done = 1'b0; exp_error = 1'b1; exp_wc = 0;
      $display("timeout");
      check_status("timeout");

      // Length overflow (MAX_WORDS = 64) then maximum length accepted
      send_byte(8'hA5);
      check("ovf_error_cleared", 32'(load_error), 32'd0);
      seq = {8'h41, 8'h00};
      send_seq(seq);
      $display("length overflow");
      check("ovf_load_error", 32'(load_error), 32'd1);
      check("ovf_debug_enable", 32'(debug_enable), 32'd0);
      run_frame(64, 1'b0, 0);

      // Randomized frames with gaps, junk bytes and restarts from ERROR
      in_run = 1'b1;
      for (int f = 0; f < 20; f++) begin
         if (in_run || $urandom_range(0, 1) == 1) do_reload();
         repeat ($urandom_range(0, 2)) begin
            junk = 8'($urandom_range(0, 255));
            if (junk == 8'hA5) junk = 8'h5A;
            send_byte(junk);
         end
         run_frame($urandom_range(0, 6), $urandom_range(0, 3) == 0, 2);
         in_run = exp_done;
      end

      // Asynchronous reset in the middle of a word
      do_reload();
      expect_write(0, 32'h00000013);
      seq = {8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
             8'h93, 8'h00, 8'h50};
      send_seq(seq);
      #2;
      rst = 1'b0;
      #1;
      exp_done = 1'b0; exp_error = 1'b0; exp_wc = 0;
      $display("async reset mid-frame");
      check("arst_instruction_write", 32'(instruction_write), 32'd0);
      check("arst_instruction_addr", 32'(instruction_addr), 32'd0);
      check("arst_instruction_in", instruction_in, 32'd0);
      check_status("arst");
      @(negedge clk);
      rst = 1'b1;
      seq = {8'h00, 8'h00, 8'h00};
      send_seq(seq);
      idle(5);
      check_status("arst_after");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
